// File: rtl/nfu_pkg.sv
// Shared definitions for the NFU partial-sum datapath: lane geometry, buffer
// and queue sizes, the controller state encoding and the in-flight tag format.
package nfu_pkg;

   localparam int BIT_WIDTH    = 16;
   localparam int Tn           = 16;
   localparam int BUS_W        = Tn * BIT_WIDTH;

   localparam int DEPTH        = 16;
   localparam int GRP_W        = $clog2(DEPTH);

   localparam int MAX_INFLIGHT = 8;
   localparam int INF_W        = $clog2(MAX_INFLIGHT) + 1;

   localparam int OUT_DEPTH    = 4;
   localparam int OUT_CNT_W    = $clog2(OUT_DEPTH) + 1;

   localparam int TILE_W       = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // One entry per issued-but-unreturned partial sum: which group it belongs
   // to and whether it was issued on the final input tile.
   typedef struct packed {
      logic [GRP_W-1:0] group;
      logic             last;
   } psum_tag_t;

   localparam int TAG_W = GRP_W + 1;

endpackage

// File: rtl/nbout_fifo.sv
// Synchronous first-word-fall-through FIFO with an occupancy count.
// A push while full or a pop while empty is dropped; both are judged on the
// occupancy before the clock edge, so push and pop may happen together.
module nbout_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_empty,
   output logic [CNT_W-1:0] o_count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wrPtr;
   logic [PTR_W-1:0] r_rdPtr;
   logic [CNT_W-1:0] r_count;

   logic w_full;
   logic w_doPush;
   logic w_doPop;

   assign w_full   = (r_count == CNT_W'(DEPTH));
   assign o_empty  = (r_count == '0);
   assign w_doPush = i_push & ~w_full;
   assign w_doPop  = i_pop & ~o_empty;
   assign o_data   = r_mem[r_rdPtr];
   assign o_count  = r_count;

   // Pointer advance with wrap, so a non-power-of-two depth still works.
   function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Storage array; contents never need clearing because count gates reads.
   always_ff @(posedge clk) begin
      if (w_doPush) begin
         r_mem[r_wrPtr] <= i_data;
      end
   end

   // Read/write pointers and occupancy, cleared by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush) begin
            r_wrPtr <= nextPtr(r_wrPtr);
         end
         if (w_doPop) begin
            r_rdPtr <= nextPtr(r_rdPtr);
         end
         case ({w_doPush, w_doPop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/nbout_psum_ctrl.sv
// NBout partial-sum controller. Streams per-group partial sums to nfu_2,
// writes the returned sums back into a per-group buffer, and on the final
// input tile forwards the returned sums into an output queue toward NFU-3.
// Loop order is input tile (outer) by output group (inner). A pending bit
// per group blocks re-issue of a group whose previous sum is still in nfu_2,
// and a credit check on the final tile keeps the output queue from overflowing.
module nbout_psum_ctrl
   import nfu_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic [GRP_W:0]    i_num_groups,
   input  logic [TILE_W-1:0] i_num_tiles,
   output logic              o_busy,
   output logic              o_done,
   output logic [BUS_W-1:0]  o_psum,
   output logic              o_psum_valid,
   input  logic              i_psum_ready,
   input  logic [BUS_W-1:0]  i_sum,
   input  logic              i_sum_valid,
   output logic [BUS_W-1:0]  o_out,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic              o_err
);

   state_t              r_state;
   logic [GRP_W:0]      r_numGroups;
   logic [TILE_W-1:0]   r_numTiles;
   logic [GRP_W-1:0]    r_grpIdx;
   logic [TILE_W-1:0]   r_tileIdx;
   logic [BUS_W-1:0]    r_buf [DEPTH];
   logic [DEPTH-1:0]    r_pending;
   logic [INF_W-1:0]    r_inflightLast;
   logic                r_err;

   logic                w_lastGrp;
   logic                w_lastTile;
   logic [INF_W:0]      w_creditSum;
   logic                w_creditOk;
   logic                w_issueOk;
   logic                w_accept;

   psum_tag_t           w_tagIn;
   logic [TAG_W-1:0]    w_tagOut;
   psum_tag_t           w_retTag;
   logic                w_tagEmpty;
   logic [INF_W-1:0]    w_tagCount;
   logic                w_tagFull;
   logic                w_retValid;

   logic [BUS_W-1:0]    w_outData;
   logic                w_outEmpty;
   logic [OUT_CNT_W-1:0] w_outCount;
   logic                w_outPush;

   // Position within the tile x group loop.
   assign w_lastGrp  = ({1'b0, r_grpIdx} == (r_numGroups - (GRP_W + 1)'(1)));
   assign w_lastTile = (r_tileIdx == (r_numTiles - TILE_W'(1)));

   // Final-tile sums already queued plus those still inside nfu_2 must leave
   // room in the output queue; this is what guarantees a return never finds
   // the output queue full.
   assign w_creditSum = (INF_W + 1)'(w_outCount) + (INF_W + 1)'(r_inflightLast);
   assign w_creditOk  = (w_creditSum < (INF_W + 1)'(OUT_DEPTH));

   assign w_tagFull  = (w_tagCount == INF_W'(MAX_INFLIGHT));

   // Every term here only changes through our own accept or through returns
   // that can only relax it, so valid and data hold steady until accepted.
   assign w_issueOk  = (r_state == RUN) & ~w_tagFull & ~r_pending[r_grpIdx] &
                       (~w_lastTile | w_creditOk);
   assign w_accept   = w_issueOk & i_psum_ready;

   assign o_psum_valid = w_issueOk;
   assign o_psum       = (r_tileIdx == '0) ? '0 : r_buf[r_grpIdx];

   assign w_tagIn.group = r_grpIdx;
   assign w_tagIn.last  = w_lastTile;
   assign w_retTag      = psum_tag_t'(w_tagOut);
   assign w_retValid    = i_sum_valid & ~w_tagEmpty;
   assign w_outPush     = w_retValid & w_retTag.last;

   assign o_out_valid = ~w_outEmpty;
   assign o_out       = w_outEmpty ? '0 : w_outData;

   assign o_busy = (r_state != IDLE);
   assign o_done = (r_state == DONE);
   assign o_err  = r_err;

   // Tags for sums in flight through nfu_2, returned strictly in issue order.
   nbout_fifo #(
      .WIDTH (TAG_W),
      .DEPTH (MAX_INFLIGHT),
      .CNT_W (INF_W)
   ) u_tagQueue (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_accept),
      .i_data  (w_tagIn),
      .i_pop   (i_sum_valid),
      .o_data  (w_tagOut),
      .o_empty (w_tagEmpty),
      .o_count (w_tagCount)
   );

   // Final sums waiting for NFU-3.
   nbout_fifo #(
      .WIDTH (BUS_W),
      .DEPTH (OUT_DEPTH),
      .CNT_W (OUT_CNT_W)
   ) u_outQueue (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_outPush),
      .i_data  (i_sum),
      .i_pop   (i_out_ready),
      .o_data  (w_outData),
      .o_empty (w_outEmpty),
      .o_count (w_outCount)
   );

   // Controller FSM: latches the job size at start, walks the group/tile
   // loop on each accepted issue, then waits for both queues to empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_numGroups <= '0;
         r_numTiles  <= '0;
         r_grpIdx    <= '0;
         r_tileIdx   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_numGroups <= i_num_groups;
                  r_numTiles  <= i_num_tiles;
                  r_grpIdx    <= '0;
                  r_tileIdx   <= '0;
                  if ((i_num_groups == '0) || (i_num_tiles == '0)) begin
                     r_state <= DONE;
                  end else begin
                     r_state <= RUN;
                  end
               end
            end
            RUN: begin
               if (w_accept) begin
                  if (w_lastGrp) begin
                     r_grpIdx <= '0;
                     if (w_lastTile) begin
                        r_tileIdx <= '0;
                        r_state   <= DRAIN;
                     end else begin
                        r_tileIdx <= r_tileIdx + 1'b1;
                     end
                  end else begin
                     r_grpIdx <= r_grpIdx + 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (w_tagEmpty && w_outEmpty) begin
                  r_state <= DONE;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Intermediate returns overwrite the group's buffer slot; contents are
   // only ever read after being written in the current job.
   always_ff @(posedge clk) begin
      if (w_retValid && !w_retTag.last) begin
         r_buf[w_retTag.group] <= i_sum;
      end
   end

   // Pending bit per group: set on a non-final issue, cleared on its return.
   // Issue and return in one cycle always target different groups.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending <= '0;
      end else begin
         if (w_retValid && !w_retTag.last) begin
            r_pending[w_retTag.group] <= 1'b0;
         end
         if (w_accept && !w_lastTile) begin
            r_pending[r_grpIdx] <= 1'b1;
         end
      end
   end

   // Count of final-tile sums inside nfu_2, used by the output credit check.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_inflightLast <= '0;
      end else begin
         case ({w_accept & w_lastTile, w_outPush})
            2'b10:   r_inflightLast <= r_inflightLast + 1'b1;
            2'b01:   r_inflightLast <= r_inflightLast - 1'b1;
            default: r_inflightLast <= r_inflightLast;
         endcase
      end
   end

   // Sticky error: a result arrived with nothing outstanding to match it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err <= 1'b0;
      end else if (i_sum_valid && w_tagEmpty) begin
         r_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_nbout_psum_ctrl.sv
// Directed bench for nbout_psum_ctrl with a small nfu_2 responder that adds
// k*0x0400 to every lane of the k-th accepted partial sum (k counts from 1
// and restarts after reset) and returns it a fixed number of cycles later.
module tb_nbout_psum_ctrl;
   import nfu_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              iStart;
   logic [GRP_W:0]    numGroups;
   logic [TILE_W-1:0] numTiles;
   logic              busy;
   logic              done;
   logic [BUS_W-1:0]  psum;
   logic              psumValid;
   logic              psumReady;
   logic [BUS_W-1:0]  sumData = '0;
   logic              sumValid = 1'b0;
   logic [BUS_W-1:0]  outData;
   logic              outValid;
   logic              outReady;
   logic              err;

   int testsRun    = 0;
   int testsFailed = 0;

   typedef struct {
      logic [BUS_W-1:0] data;
      int               due;
   } ret_t;

   ret_t             modelQ[$];
   logic [BUS_W-1:0] acceptedPsum[$];
   int               acceptCyc[$];
   logic [BUS_W-1:0] outQ[$];
   int               cyc       = 0;
   int               issueNum  = 0;
   int               modelLat  = 2;
   logic             manualSum = 1'b0;

   always #5 clk = ~clk;

   nbout_psum_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_start      (iStart),
      .i_num_groups (numGroups),
      .i_num_tiles  (numTiles),
      .o_busy       (busy),
      .o_done       (done),
      .o_psum       (psum),
      .o_psum_valid (psumValid),
      .i_psum_ready (psumReady),
      .i_sum        (sumData),
      .i_sum_valid  (sumValid),
      .o_out        (outData),
      .o_out_valid  (outValid),
      .i_out_ready  (outReady),
      .o_err        (err)
   );

   function automatic logic [BUS_W-1:0] lanes(input logic [BIT_WIDTH-1:0] v);
      return {Tn{v}};
   endfunction

   function automatic logic [BUS_W-1:0] addLanes(input logic [BUS_W-1:0] a,
                                                 input logic [BIT_WIDTH-1:0] inc);
      logic [BUS_W-1:0] r;
      for (int i = 0; i < Tn; i++) begin
         r[i*BIT_WIDTH +: BIT_WIDTH] = a[i*BIT_WIDTH +: BIT_WIDTH] + inc;
      end
      return r;
   endfunction

   // Responder and monitor: sees pre-edge handshakes at each rising edge.
   always @(posedge clk) begin
      ret_t r;
      cyc = cyc + 1;
      if (!rst_n) begin
         modelQ.delete();
         issueNum = 0;
      end else begin
         if (psumValid && psumReady) begin
            issueNum = issueNum + 1;
            r.data = addLanes(psum, BIT_WIDTH'(issueNum * 'h0400));
            r.due  = cyc + modelLat;
            modelQ.push_back(r);
            acceptedPsum.push_back(psum);
            acceptCyc.push_back(cyc);
         end
         if (outValid && outReady) begin
            outQ.push_back(outData);
         end
      end
   end

   // Present due results at the falling edge so the next rising edge samples them.
   always @(negedge clk) begin
      sumValid = 1'b0;
      sumData  = '0;
      if (rst_n && (modelQ.size() > 0) && (modelQ[0].due <= cyc + 1)) begin
         sumValid = 1'b1;
         sumData  = modelQ[0].data;
         void'(modelQ.pop_front());
      end
      if (manualSum) begin
         sumValid = 1'b1;
         sumData  = lanes(16'hBEEF);
      end
   end

   task automatic checkOutput(input string tag, input logic [BUS_W-1:0] observed,
                              input logic [BUS_W-1:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [GRP_W:0] g, input logic [TILE_W-1:0] t,
                                input int lat, input logic outRdy);
      @(negedge clk);
      modelLat  = lat;
      outReady  = outRdy;
      numGroups = g;
      numTiles  = t;
      iStart    = 1'b1;
      acceptedPsum.delete();
      acceptCyc.delete();
      outQ.delete();
      @(negedge clk);
      iStart = 1'b0;
   endtask

   task automatic waitDone(input int maxCycles, input string tag);
      int n = 0;
      while (!done && n < maxCycles) begin
         @(negedge clk);
         n++;
      end
      checkOutput(tag, BUS_W'(done), BUS_W'(1));
   endtask

   initial begin
      rst_n     = 1'b0;
      iStart    = 1'b0;
      numGroups = '0;
      numTiles  = '0;
      psumReady = 1'b1;
      outReady  = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("rstBusy",      BUS_W'(busy),      '0);
      checkOutput("rstDone",      BUS_W'(done),      '0);
      checkOutput("rstPsumValid", BUS_W'(psumValid), '0);
      checkOutput("rstPsum",      psum,              '0);
      checkOutput("rstOutValid",  BUS_W'(outValid),  '0);
      checkOutput("rstOut",       outData,           '0);
      checkOutput("rstErr",       BUS_W'(err),       '0);
      rst_n = 1'b1;

      // G=2, T=1, latency 2: both issues carry zero, results 0x0400 and 0x0800.
      applyStimulus(5'd2, 16'd1, 2, 1'b1);
      checkOutput("t1FirstValid", BUS_W'(psumValid), BUS_W'(1));
      waitDone(40, "t1Done");
      checkOutput("t1Issues", BUS_W'(acceptedPsum.size()), BUS_W'(2));
      checkOutput("t1Psum0",  acceptedPsum[0], '0);
      checkOutput("t1Psum1",  acceptedPsum[1], '0);
      checkOutput("t1OutCnt", BUS_W'(outQ.size()), BUS_W'(2));
      checkOutput("t1Out0",   outQ[0], lanes(16'h0400));
      checkOutput("t1Out1",   outQ[1], lanes(16'h0800));
      @(negedge clk);
      checkOutput("t1DonePulse", BUS_W'(done), '0);
      checkOutput("t1Idle",      BUS_W'(busy), '0);

      // G=1, T=3, latency 3: each issue waits for the previous writeback.
      applyStimulus(5'd1, 16'd3, 3, 1'b1);
      waitDone(80, "t2Done");
      checkOutput("t2Issues", BUS_W'(acceptedPsum.size()), BUS_W'(3));
      checkOutput("t2Psum0",  acceptedPsum[0], '0);
      checkOutput("t2Psum1",  acceptedPsum[1], lanes(16'h0C00));
      checkOutput("t2Psum2",  acceptedPsum[2], lanes(16'h1C00));
      checkOutput("t2Gap1",   BUS_W'(acceptCyc[1] - acceptCyc[0]), BUS_W'(4));
      checkOutput("t2Gap2",   BUS_W'(acceptCyc[2] - acceptCyc[1]), BUS_W'(4));
      checkOutput("t2OutCnt", BUS_W'(outQ.size()), BUS_W'(1));
      checkOutput("t2Out0",   outQ[0], lanes(16'h3000));

      // G=8, T=1 with NFU-3 stalled: credit limits issues to the queue depth.
      applyStimulus(5'd8, 16'd1, 2, 1'b0);
      repeat (30) @(negedge clk);
      checkOutput("t3StallIssues", BUS_W'(acceptedPsum.size()), BUS_W'(OUT_DEPTH));
      checkOutput("t3StallValid",  BUS_W'(outValid), BUS_W'(1));
      checkOutput("t3StallBusy",   BUS_W'(busy), BUS_W'(1));
      outReady = 1'b1;
      waitDone(100, "t3Done");
      checkOutput("t3Issues", BUS_W'(acceptedPsum.size()), BUS_W'(8));
      checkOutput("t3OutCnt", BUS_W'(outQ.size()), BUS_W'(8));
      for (int i = 0; i < 8; i++) begin
         checkOutput($sformatf("t3Out%0d", i), outQ[i],
                     lanes(BIT_WIDTH'((6 + i) * 'h0400)));
      end

      // Zero groups: straight to DONE for one cycle, nothing issued.
      applyStimulus(5'd0, 16'd5, 2, 1'b1);
      checkOutput("t4Done",      BUS_W'(done), BUS_W'(1));
      checkOutput("t4PsumValid", BUS_W'(psumValid), '0);
      @(negedge clk);
      checkOutput("t4DoneLow",   BUS_W'(done), '0);
      checkOutput("t4Idle",      BUS_W'(busy), '0);
      checkOutput("t4NoIssue",   BUS_W'(acceptedPsum.size()), '0);

      // Reset in the middle of a run, then a clean G=2, T=2 job.
      applyStimulus(5'd2, 16'd2, 2, 1'b1);
      @(negedge clk);
      checkOutput("t5MidBusy", BUS_W'(busy), BUS_W'(1));
      #2 rst_n = 1'b0;
      #1;
      checkOutput("t5RstBusy",      BUS_W'(busy), '0);
      checkOutput("t5RstPsumValid", BUS_W'(psumValid), '0);
      checkOutput("t5RstPsum",      psum, '0);
      checkOutput("t5RstOutValid",  BUS_W'(outValid), '0);
      checkOutput("t5RstDone",      BUS_W'(done), '0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(5'd2, 16'd2, 2, 1'b1);
      waitDone(60, "t5Done");
      checkOutput("t5Issues", BUS_W'(acceptedPsum.size()), BUS_W'(4));
      checkOutput("t5Psum2",  acceptedPsum[2], lanes(16'h0400));
      checkOutput("t5Psum3",  acceptedPsum[3], lanes(16'h0800));
      checkOutput("t5OutCnt", BUS_W'(outQ.size()), BUS_W'(2));
      checkOutput("t5Out0",   outQ[0], lanes(16'h1000));
      checkOutput("t5Out1",   outQ[1], lanes(16'h1800));

      // Stray result while idle raises the sticky error and changes nothing else.
      checkOutput("t6ErrBefore", BUS_W'(err), '0);
      @(posedge clk);
      #1 manualSum = 1'b1;
      @(posedge clk);
      #1 manualSum = 1'b0;
      checkOutput("t6ErrSet",   BUS_W'(err), BUS_W'(1));
      checkOutput("t6Idle",     BUS_W'(busy), '0);
      checkOutput("t6NoOut",    BUS_W'(outValid), '0);
      repeat (3) @(negedge clk);
      checkOutput("t6ErrStick", BUS_W'(err), BUS_W'(1));
      checkOutput("t6StillIdle", BUS_W'(busy), '0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
